// File: rtl/pmod8led2_drv.sv
// Driver for an 8-LED bi-color PMOD: per-LED red/green/yellow with global PWM
// brightness, per-LED blinking and frame-synchronous (double-buffered) updates.
module pmod8led2_drv #(
  parameter int PRESCALE     = 47,
  parameter int BLINK_FRAMES = 8000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] led_data,
  input  logic [7:0]  blink_mask,
  input  logic [3:0]  bright,
  input  logic        load,
  output logic        upd_pend,
  output logic [0:7]  pmodledg,
  output logic [0:7]  pmodledr
);

  localparam logic [15:0] PS_MAX = 16'(PRESCALE - 1);
  localparam logic [15:0] BF_MAX = 16'(BLINK_FRAMES - 1);

  logic [15:0] pcnt_reg;
  logic [3:0]  phase_reg;
  logic [15:0] fcnt_reg;
  logic        ysel_reg;
  logic        blink_on_reg;

  logic [15:0] sh_data_reg;
  logic [7:0]  sh_mask_reg;
  logic [3:0]  sh_bright_reg;
  logic [15:0] act_data_reg;
  logic [7:0]  act_mask_reg;
  logic [3:0]  act_bright_reg;
  logic        upd_pend_reg;

  logic [0:7]  red_next;
  logic [0:7]  grn_next;

  logic tick;
  logic frame_end;
  logic pwm_on;

  assign tick      = (pcnt_reg == PS_MAX);
  assign frame_end = tick && (phase_reg == 4'hF);
  assign pwm_on    = (act_bright_reg == 4'hF) || (phase_reg < act_bright_reg);
  assign upd_pend  = upd_pend_reg;

  // Timebase: prescaler -> PWM phase -> frame -> blink half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_reg     <= '0;
      phase_reg    <= '0;
      fcnt_reg     <= '0;
      ysel_reg     <= 1'b0;
      blink_on_reg <= 1'b1;
    end else begin
      if (tick) begin
        pcnt_reg  <= '0;
        phase_reg <= phase_reg + 4'd1;
      end else begin
        pcnt_reg <= pcnt_reg + 16'd1;
      end
      if (frame_end) begin
        ysel_reg <= ~ysel_reg;
        if (fcnt_reg == BF_MAX) begin
          fcnt_reg     <= '0;
          blink_on_reg <= ~blink_on_reg;
        end else begin
          fcnt_reg <= fcnt_reg + 16'd1;
        end
      end
    end
  end

  // Active set only ever changes on frame_end, so a frame's duty is never cut short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_data_reg    <= '0;
      sh_mask_reg    <= '0;
      sh_bright_reg  <= '0;
      act_data_reg   <= '0;
      act_mask_reg   <= '0;
      act_bright_reg <= '0;
      upd_pend_reg   <= 1'b0;
    end else begin
      if (load) begin
        sh_data_reg   <= led_data;
        sh_mask_reg   <= blink_mask;
        sh_bright_reg <= bright;
      end
      if (load && frame_end) begin
        act_data_reg   <= led_data;
        act_mask_reg   <= blink_mask;
        act_bright_reg <= bright;
        upd_pend_reg   <= 1'b0;
      end else if (load) begin
        upd_pend_reg <= 1'b1;
      end else if (frame_end && upd_pend_reg) begin
        act_data_reg   <= sh_data_reg;
        act_mask_reg   <= sh_mask_reg;
        act_bright_reg <= sh_bright_reg;
        upd_pend_reg   <= 1'b0;
      end
    end
  end

  // Yellow alternates red/green frames, so both cathodes are never driven together.
  for (genvar gi = 0; gi < 8; gi++) begin : g_led
    logic [1:0] code;
    logic       vis;
    assign code          = act_data_reg[2*gi+1 -: 2];
    assign vis           = pwm_on && (blink_on_reg || !act_mask_reg[gi]);
    assign red_next[gi]  = vis && ((code == 2'b01) || ((code == 2'b11) && !ysel_reg));
    assign grn_next[gi]  = vis && ((code == 2'b10) || ((code == 2'b11) && ysel_reg));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pmodledr <= '0;
      pmodledg <= '0;
    end else begin
      pmodledr <= red_next;
      pmodledg <= grn_next;
    end
  end

endmodule

// File: tb/tb_pmod8led2_drv.sv
// Directed bench for pmod8led2_drv with PRESCALE=2, BLINK_FRAMES=4
// (32-cycle frames, frame_end on edges 32, 64, ... counted from reset release).
module tb_pmod8led2_drv;

  logic        clk;
  logic        rst_n;
  logic [15:0] led_data;
  logic [7:0]  blink_mask;
  logic [3:0]  bright;
  logic        load;
  logic        upd_pend;
  logic [0:7]  ledg;
  logic [0:7]  ledr;

  int n_cmp;
  int n_bad;
  int cyc;

  pmod8led2_drv #(
    .PRESCALE    (2),
    .BLINK_FRAMES(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .led_data  (led_data),
    .blink_mask(blink_mask),
    .bright    (bright),
    .load      (load),
    .upd_pend  (upd_pend),
    .pmodledg  (ledg),
    .pmodledr  (ledr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  // Load is sampled on edge 'target'; returns just after that edge.
  task automatic do_load(input int target, input logic [15:0] d, input logic [7:0] m,
                         input logic [3:0] b);
    run_to(target - 1);
    led_data   = d;
    blink_mask = m;
    bright     = b;
    load       = 1'b1;
    step();
    load = 1'b0;
    $display("load  cyc=%0d data=%h mask=%h bright=%0d", cyc, d, m, b);
  endtask

  initial begin
    int cnt;
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;

    // Reset held, with a load that must be ignored.
    rst_n      = 1'b0;
    load       = 1'b1;
    led_data   = 16'hFFFF;
    blink_mask = 8'hFF;
    bright     = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    load = 1'b0;
    chk("rst_pend", 32'(upd_pend), 32'h0);
    chk("rst_r", 32'(ledr), 32'h0);
    chk("rst_g", 32'(ledg), 32'h0);
    rst_n = 1'b1;
    cyc   = 0;

    // LED0 red, full brightness; applied at frame_end edge 32.
    do_load(1, 16'h0001, 8'h00, 4'hF);
    chk("a_pend1", 32'(upd_pend), 32'h1);
    run_to(31);
    chk("a_pend31", 32'(upd_pend), 32'h1);
    chk("a_r31", 32'(ledr), 32'h0);
    run_to(32);
    chk("a_pend32", 32'(upd_pend), 32'h0);
    run_to(33);
    chk("a_r33", 32'(ledr), 32'h80);
    chk("a_g33", 32'(ledg), 32'h0);
    run_to(38);
    chk("a_r38", 32'(ledr), 32'h80);

    // LED3 yellow: red while ysel=0 (edges 65..96), green while ysel=1 (97..128).
    do_load(40, 16'h00C0, 8'h00, 4'hF);
    run_to(70);
    chk("b_r70", 32'(ledr), 32'h10);
    chk("b_g70", 32'(ledg), 32'h0);
    run_to(96);
    chk("b_r96", 32'(ledr), 32'h10);
    run_to(97);
    chk("b_g97", 32'(ledg), 32'h10);
    chk("b_r97", 32'(ledr), 32'h0);
    while (cyc < 105) begin
      step();
      chk("b_excl", 32'(ledr & ledg), 32'h0);
    end

    // LED0 green at bright=4: phases 0..3 -> 8 of 32 cycles (edges 129..136).
    do_load(110, 16'h0002, 8'h00, 4'd4);
    run_to(128);
    cnt = 0;
    while (cyc < 160) begin
      step();
      if (ledg[0]) cnt++;
      if (cyc == 136) chk("c_g136", 32'(ledg), 32'h80);
      if (cyc == 137) chk("c_g137", 32'(ledg), 32'h0);
    end
    chk("c_duty4", 32'(cnt), 32'd8);

    // bright=0: always off.
    do_load(170, 16'h0002, 8'h00, 4'd0);
    run_to(192);
    cnt = 0;
    while (cyc < 224) begin
      step();
      if (ledg[0]) cnt++;
    end
    chk("c_duty0", 32'(cnt), 32'd0);

    // LED0 blinking + LED1 steady red; blink_on is 1 for 257..384, 0 for 385..512.
    do_load(230, 16'h0005, 8'h01, 4'hF);
    run_to(300);
    chk("d_r300", 32'(ledr), 32'hC0);
    run_to(384);
    chk("d_r384", 32'(ledr), 32'hC0);
    run_to(385);
    chk("d_r385", 32'(ledr), 32'h40);
    run_to(450);
    chk("d_r450", 32'(ledr), 32'h40);
    run_to(513);
    chk("d_r513", 32'(ledr), 32'hC0);

    // Two loads in one frame: last wins at edge 544.
    do_load(520, 16'h0001, 8'h00, 4'hF);
    chk("e_pend520", 32'(upd_pend), 32'h1);
    do_load(530, 16'h0002, 8'h00, 4'hF);
    chk("e_pend530", 32'(upd_pend), 32'h1);
    run_to(544);
    chk("e_pend544", 32'(upd_pend), 32'h0);
    run_to(545);
    chk("e_g545", 32'(ledg), 32'h80);
    chk("e_r545", 32'(ledr), 32'h0);

    // Load coinciding with frame_end (edge 576) is applied at once.
    do_load(576, 16'h0001, 8'h00, 4'hF);
    chk("e_pend576", 32'(upd_pend), 32'h0);
    run_to(577);
    chk("e_r577", 32'(ledr), 32'h80);
    chk("e_g577", 32'(ledg), 32'h0);

    // Reset mid-frame with an update pending.
    do_load(590, 16'h0002, 8'h00, 4'hF);
    run_to(601);
    chk("f_pend", 32'(upd_pend), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("f_async_r", 32'(ledr), 32'h0);
    chk("f_async_g", 32'(ledg), 32'h0);
    chk("f_async_pend", 32'(upd_pend), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    run_to(40);
    chk("f_stale_r", 32'(ledr), 32'h0);
    chk("f_stale_g", 32'(ledg), 32'h0);
    chk("f_stale_pend", 32'(upd_pend), 32'h0);

    // Fresh load after reset: frame timing restarts from release.
    do_load(41, 16'h0002, 8'h00, 4'hF);
    run_to(64);
    chk("f_pend64", 32'(upd_pend), 32'h0);
    run_to(65);
    chk("f_g65", 32'(ledg), 32'h80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
